// File: rtl/sseg2bcd_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment display bus.
// Each digit pattern must be stable before capture; full frames are published with a strobe.
module sseg2bcd_capture #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            sseg,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  bcd_valid,
  output logic                  pattern_err
);

  // state  | meaning
  // IDLE   | no single digit selected
  // SETTLE | one digit selected, counting identical samples
  // HOLD   | current digit captured, waiting for the bus to change
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [N_DIGITS-1:0]   an_q, an_p;
  logic [6:0]            sseg_q, sseg_p;
  logic [4*N_DIGITS-1:0] staging, stage_nxt;
  logic [N_DIGITS-1:0]   err_flags, err_nxt;
  logic [N_DIGITS-1:0]   mask, mask_nxt;
  logic                  legal, changed, wr_en, dec_err;
  logic [IW-1:0]         sel_idx;
  logic [3:0]            dec_val;
  int                    low_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      sseg_q <= '1;
      an_p   <= '1;
      sseg_p <= '1;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      an_p   <= an_q;
      sseg_p <= sseg_q;
    end
  end

  always_comb begin
    low_cnt = 0;
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 1;
        sel_idx = IW'(i);
      end
    end
    legal   = (low_cnt == 1);
    changed = (an_q != an_p) || (sseg_q != sseg_p);
  end

  // Segment order in sseg_q is {g,f,e,d,c,b,a}, lit segments are 0.
  always_comb begin
    dec_err = 1'b0;
    case (sseg_q)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0011000: dec_val = 4'd9;
      7'b1111111: dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      SETTLE: begin
        if (!legal) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt = CW'(1);
        end else if (cnt == CW'(STABLE_CYCLES)) begin
          wr_en     = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!legal) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    stage_nxt = staging;
    err_nxt   = err_flags;
    mask_nxt  = mask;
    if (wr_en) begin
      stage_nxt[{sel_idx, 2'b00} +: 4] = dec_val;
      err_nxt[sel_idx]                 = dec_err;
      mask_nxt[sel_idx]                = 1'b1;
    end
  end

  // A slot written on the publishing edge is folded into the published frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging     <= '0;
      err_flags   <= '0;
      mask        <= '0;
      bcd         <= '0;
      bcd_valid   <= 1'b0;
      pattern_err <= 1'b0;
    end else if (&mask) begin
      staging     <= stage_nxt;
      err_flags   <= '0;
      mask        <= '0;
      bcd         <= stage_nxt;
      bcd_valid   <= 1'b1;
      pattern_err <= |err_nxt;
    end else begin
      staging     <= stage_nxt;
      err_flags   <= err_nxt;
      mask        <= mask_nxt;
      bcd_valid   <= 1'b0;
      pattern_err <= 1'b0;
    end
  end

endmodule
